// File: rtl/nb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nb_pkg                                                     |
// | Brief   : Shared types and constants for the non-bonded scheduler.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package nb_pkg;

    localparam int unsigned c_q_width         = 32;
    localparam int unsigned c_latency_default = 18;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } nb_state_e;

    function automatic logic [c_q_width-1:0] nb_abs(input logic [c_q_width-1:0] d);
        return d[c_q_width-1] ? (~d + 1'b1) : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nb_tag_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nb_tag_delay                                               |
// | Brief   : Fixed-depth shift register carrying pair tags beside the   |
// |           external pipeline.                                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nb_tag_delay #(
    parameter int DEPTH = 18,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_tag,
    output logic [WIDTH-1:0] o_tag
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_stage[g] <= '0;
                else        r_stage[g] <= i_tag;
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_stage[g] <= '0;
                else        r_stage[g] <= r_stage[g-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/nb_pair_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nb_pair_scheduler                                          |
// | Brief   : Issues all (i<j) atom pairs to a fixed-latency force       |
// |           pipeline and accumulates Newton-3 forces per atom.         |
// |           Define NB_CUTOFF_EN to add the cutoff_box pair filter.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nb_pair_scheduler
    import nb_pkg::*;
#(
    parameter int MAX_ATOMS = 16,
    parameter int LATENCY   = c_latency_default
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ld_we,
    input  logic [$clog2(MAX_ATOMS)-1:0] ld_addr,
    input  logic [c_q_width-1:0]         ld_x,
    input  logic [c_q_width-1:0]         ld_y,
    input  logic [c_q_width-1:0]         ld_z,
    input  logic [c_q_width-1:0]         ld_q,
    input  logic [$clog2(MAX_ATOMS):0]   n_atoms,
    input  logic [c_q_width-1:0]         sigma_sq,
    input  logic [c_q_width-1:0]         eps_x24,
`ifdef NB_CUTOFF_EN
    input  logic [c_q_width-1:0]         cutoff_box,
`endif
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         pipe_valid_in,
    output logic [c_q_width-1:0]         pipe_xi,
    output logic [c_q_width-1:0]         pipe_yi,
    output logic [c_q_width-1:0]         pipe_zi,
    output logic [c_q_width-1:0]         pipe_xj,
    output logic [c_q_width-1:0]         pipe_yj,
    output logic [c_q_width-1:0]         pipe_zj,
    output logic [c_q_width-1:0]         pipe_qi,
    output logic [c_q_width-1:0]         pipe_qj,
    output logic [c_q_width-1:0]         pipe_sigma_sq,
    output logic [c_q_width-1:0]         pipe_eps_x24,
    input  logic                         pipe_valid_out,
    input  logic [c_q_width-1:0]         pipe_fx,
    input  logic [c_q_width-1:0]         pipe_fy,
    input  logic [c_q_width-1:0]         pipe_fz,
    input  logic [$clog2(MAX_ATOMS)-1:0] rd_addr,
    output logic [c_q_width-1:0]         rd_fx,
    output logic [c_q_width-1:0]         rd_fy,
    output logic [c_q_width-1:0]         rd_fz
);

    localparam int c_aw = $clog2(MAX_ATOMS);
    localparam int c_tw = 2 * c_aw + 1;
    localparam int c_cw = $clog2(LATENCY + 2) + 1;

    nb_state_e             r_state;
    nb_state_e             w_state_nxt;
    logic [c_q_width-1:0]  r_tx [MAX_ATOMS];
    logic [c_q_width-1:0]  r_ty [MAX_ATOMS];
    logic [c_q_width-1:0]  r_tz [MAX_ATOMS];
    logic [c_q_width-1:0]  r_tq [MAX_ATOMS];
    logic [c_q_width-1:0]  w_acc_x [MAX_ATOMS];
    logic [c_q_width-1:0]  w_acc_y [MAX_ATOMS];
    logic [c_q_width-1:0]  w_acc_z [MAX_ATOMS];
    logic [c_aw:0]         r_n;
    logic [c_aw-1:0]       r_i;
    logic [c_aw-1:0]       r_j;
    logic [c_q_width-1:0]  r_hxi, r_hyi, r_hzi, r_hqi;
    logic [c_q_width-1:0]  r_hxj, r_hyj, r_hzj, r_hqj;
    logic [c_cw-1:0]       r_inflight;
    logic                  r_err;
    logic                  r_armed;
    logic                  w_near;
    logic                  w_issue;
    logic                  w_last_pair;
    logic                  w_acc_en;
    logic [c_tw-1:0]       w_tag_in;
    logic [c_tw-1:0]       w_tag_out;
    logic                  w_tag_v;
    logic [c_aw-1:0]       w_tag_i;
    logic [c_aw-1:0]       w_tag_j;

`ifdef NB_CUTOFF_EN
    logic [c_q_width-1:0] w_dx, w_dy, w_dz;
    assign w_dx   = r_tx[r_j] - r_tx[r_i];
    assign w_dy   = r_ty[r_j] - r_ty[r_i];
    assign w_dz   = r_tz[r_j] - r_tz[r_i];
    // A skipped pair still advances the pair counter but never reaches the pipeline.
    assign w_near = !((nb_abs(w_dx) > cutoff_box) ||
                      (nb_abs(w_dy) > cutoff_box) ||
                      (nb_abs(w_dz) > cutoff_box));
`else
    assign w_near = 1'b1;
`endif

    assign w_issue     = (r_state == ISSUE) && w_near;
    assign w_last_pair = ({1'b0, r_i} == r_n - (c_aw+1)'(2)) &&
                         ({1'b0, r_j} == r_n - (c_aw+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = CLEAR;
            CLEAR:   w_state_nxt = (r_n >= (c_aw+1)'(2)) ? ISSUE : DONE;
            ISSUE:   if (w_last_pair) w_state_nxt = DRAIN;
            DRAIN:   if (r_inflight == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_ATOMS; k++) begin
                r_tx[k] <= '0;
                r_ty[k] <= '0;
                r_tz[k] <= '0;
                r_tq[k] <= '0;
            end
        end else if (ld_we && (r_state == IDLE)) begin
            r_tx[ld_addr] <= ld_x;
            r_ty[ld_addr] <= ld_y;
            r_tz[ld_addr] <= ld_z;
            r_tq[ld_addr] <= ld_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n        <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
            r_armed    <= 1'b0;
            {r_hxi, r_hyi, r_hzi, r_hqi} <= '0;
            {r_hxj, r_hyj, r_hzj, r_hqj} <= '0;
        end else begin
            if ((r_state == IDLE) && start) r_n <= n_atoms;

            if (r_state == CLEAR) begin
                r_i <= '0;
                r_j <= c_aw'(1);
            end else if ((r_state == ISSUE) && !w_last_pair) begin
                if ({1'b0, r_j} == r_n - (c_aw+1)'(1)) begin
                    r_i <= r_i + c_aw'(1);
                    r_j <= r_i + c_aw'(2);
                end else begin
                    r_j <= r_j + c_aw'(1);
                end
            end

            if (w_issue) begin
                {r_hxi, r_hyi, r_hzi, r_hqi} <= {r_tx[r_i], r_ty[r_i], r_tz[r_i], r_tq[r_i]};
                {r_hxj, r_hyj, r_hzj, r_hqj} <= {r_tx[r_j], r_ty[r_j], r_tz[r_j], r_tq[r_j]};
            end

            case ({w_issue, pipe_valid_out && (r_inflight != '0)})
                2'b10:   r_inflight <= r_inflight + c_cw'(1);
                2'b01:   r_inflight <= r_inflight - c_cw'(1);
                default: r_inflight <= r_inflight;
            endcase

            // Only a run started since the last reset may flag a tag mismatch.
            if (r_state == CLEAR) begin
                r_armed <= 1'b1;
                r_err   <= 1'b0;
            end else if (r_armed && (pipe_valid_out != w_tag_v)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Empty slots carry index (0,0) so a stray result nets to zero.
    assign w_tag_in = w_issue ? {1'b1, r_i, r_j} : '0;

    nb_tag_delay #(
        .DEPTH (LATENCY),
        .WIDTH (c_tw)
    ) u_tag_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign {w_tag_v, w_tag_i, w_tag_j} = w_tag_out;
    assign w_acc_en = pipe_valid_out && r_armed;

    for (genvar k = 0; k < MAX_ATOMS; k++) begin : g_acc
        logic                 w_hit_i;
        logic                 w_hit_j;
        logic [c_q_width-1:0] r_ax, r_ay, r_az;

        assign w_hit_i = w_acc_en && (w_tag_i == c_aw'(k));
        assign w_hit_j = w_acc_en && (w_tag_j == c_aw'(k));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                {r_ax, r_ay, r_az} <= '0;
            end else if (r_state == CLEAR) begin
                {r_ax, r_ay, r_az} <= '0;
            end else begin
                r_ax <= r_ax + (w_hit_i ? pipe_fx : '0) - (w_hit_j ? pipe_fx : '0);
                r_ay <= r_ay + (w_hit_i ? pipe_fy : '0) - (w_hit_j ? pipe_fy : '0);
                r_az <= r_az + (w_hit_i ? pipe_fz : '0) - (w_hit_j ? pipe_fz : '0);
            end
        end

        assign w_acc_x[k] = r_ax;
        assign w_acc_y[k] = r_ay;
        assign w_acc_z[k] = r_az;
    end

    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign err           = r_err;
    assign pipe_valid_in = w_issue;
    assign pipe_xi       = w_issue ? r_tx[r_i] : r_hxi;
    assign pipe_yi       = w_issue ? r_ty[r_i] : r_hyi;
    assign pipe_zi       = w_issue ? r_tz[r_i] : r_hzi;
    assign pipe_qi       = w_issue ? r_tq[r_i] : r_hqi;
    assign pipe_xj       = w_issue ? r_tx[r_j] : r_hxj;
    assign pipe_yj       = w_issue ? r_ty[r_j] : r_hyj;
    assign pipe_zj       = w_issue ? r_tz[r_j] : r_hzj;
    assign pipe_qj       = w_issue ? r_tq[r_j] : r_hqj;
    assign pipe_sigma_sq = sigma_sq;
    assign pipe_eps_x24  = eps_x24;
    assign rd_fx         = w_acc_x[rd_addr];
    assign rd_fy         = w_acc_y[rd_addr];
    assign rd_fz         = w_acc_z[rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_nb_pair_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_nb_pair_scheduler                                       |
// | Brief   : Directed bench with a difference-force pipeline model:     |
// |           f = r_i - r_j, so atom k ends with sum_l (r_k - r_l).      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_nb_pair_scheduler;
    import nb_pkg::*;

    localparam int MAXA = 16;
    localparam int LAT  = 18;
    localparam int AW   = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          ld_we    = 1'b0;
    logic [AW-1:0] ld_addr  = '0;
    logic [31:0]   ld_x     = '0;
    logic [31:0]   ld_y     = '0;
    logic [31:0]   ld_z     = '0;
    logic [31:0]   ld_q     = '0;
    logic [AW:0]   n_atoms  = '0;
    logic [31:0]   sigma_sq = 32'h1111_1111;
    logic [31:0]   eps_x24  = 32'h2222_2222;
`ifdef NB_CUTOFF_EN
    logic [31:0]   cutoff_box = '0;
`endif
    logic          start    = 1'b0;
    logic          busy, done, err, pipe_valid_in;
    logic [31:0]   pipe_xi, pipe_yi, pipe_zi, pipe_xj, pipe_yj, pipe_zj, pipe_qi, pipe_qj;
    logic [31:0]   pipe_sigma_sq, pipe_eps_x24;
    logic          pipe_valid_out;
    logic [31:0]   pipe_fx, pipe_fy, pipe_fz;
    logic [AW-1:0] rd_addr  = '0;
    logic [31:0]   rd_fx, rd_fy, rd_fz;
    logic          inj_v    = 1'b0;
    logic [31:0]   inj_f    = '0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    nb_pair_scheduler #(.MAX_ATOMS(MAXA), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_x(ld_x), .ld_y(ld_y), .ld_z(ld_z), .ld_q(ld_q), .n_atoms(n_atoms),
        .sigma_sq(sigma_sq), .eps_x24(eps_x24),
`ifdef NB_CUTOFF_EN
        .cutoff_box(cutoff_box),
`endif
        .start(start), .busy(busy), .done(done), .err(err), .pipe_valid_in(pipe_valid_in),
        .pipe_xi(pipe_xi), .pipe_yi(pipe_yi), .pipe_zi(pipe_zi),
        .pipe_xj(pipe_xj), .pipe_yj(pipe_yj), .pipe_zj(pipe_zj),
        .pipe_qi(pipe_qi), .pipe_qj(pipe_qj),
        .pipe_sigma_sq(pipe_sigma_sq), .pipe_eps_x24(pipe_eps_x24),
        .pipe_valid_out(pipe_valid_out), .pipe_fx(pipe_fx), .pipe_fy(pipe_fy), .pipe_fz(pipe_fz),
        .rd_addr(rd_addr), .rd_fx(rd_fx), .rd_fy(rd_fy), .rd_fz(rd_fz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External pipeline model, deliberately not reset.
    logic [LAT-1:0] m_v = '0;
    logic [31:0]    m_fx [LAT];
    logic [31:0]    m_fy [LAT];
    logic [31:0]    m_fz [LAT];
    always @(posedge clk) begin
        m_v      <= {m_v[LAT-2:0], pipe_valid_in};
        m_fx[0]  <= pipe_xi - pipe_xj;
        m_fy[0]  <= pipe_yi - pipe_yj;
        m_fz[0]  <= (pipe_zi - pipe_zj) + (pipe_qi - pipe_qj);
        for (int k = 1; k < LAT; k++) begin
            m_fx[k] <= m_fx[k-1];
            m_fy[k] <= m_fy[k-1];
            m_fz[k] <= m_fz[k-1];
        end
    end
    assign pipe_valid_out = m_v[LAT-1] | inj_v;
    assign pipe_fx = inj_v ? inj_f : m_fx[LAT-1];
    assign pipe_fy = inj_v ? inj_f : m_fy[LAT-1];
    assign pipe_fz = inj_v ? inj_f : m_fz[LAT-1];

    int          n_issue = 0;
    int          n_done  = 0;
    int          n_vout  = 0;
    int          done_cyc = 0;
    logic [31:0] log_xi [1024];
    logic [31:0] log_xj [1024];
    int          log_cyc [1024];
    always @(negedge clk) begin
        if (pipe_valid_in) begin
            if (n_issue < 1024) begin
                log_xi[n_issue]  = pipe_xi;
                log_xj[n_issue]  = pipe_xj;
                log_cyc[n_issue] = cyc;
            end
            n_issue++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (pipe_valid_out) n_vout++;
    end

    int start_cyc, base_issue, base_done, base_vout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input int a, input int comp, input logic [31:0] exp);
        rd_addr = AW'(a);
        #1;
        check(tag, (comp == 0) ? rd_fx : (comp == 1) ? rd_fy : rd_fz, exp);
    endtask

    task automatic load(input int a, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = AW'(a); ld_x = x; ld_y = y; ld_z = z; ld_q = '0;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic kick(input int n);
        @(negedge clk);
        n_atoms = (AW+1)'(n); start = 1'b1;
        start_cyc = cyc; base_issue = n_issue; base_done = n_done;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_issue(input int target, input int budget);
        int k = 0;
        while (n_issue < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_issue < target) check("issue_timeout", 32'(n_issue), 32'(target));
    endtask

    initial begin
        logic [31:0] sum;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_vin", 32'(pipe_valid_in), 32'd0);
        check("rst_xi", pipe_xi, 32'd0);
        chk_rd("rst_fx5", 5, 0, 32'd0);
        rst_n = 1'b1;
        check("sigma_thru", pipe_sigma_sq, 32'h1111_1111);
        check("eps_thru", pipe_eps_x24, 32'h2222_2222);

        // N=2 single pair
        load(0, 32'h0, 32'h0, 32'h0);
        load(1, 32'h0002_0000, 32'h0001_0000, 32'h0);
        kick(2);
        wait_done(100);
        check("n2_issues", 32'(n_issue - base_issue), 32'd1);
        check("n2_done_lat", 32'(done_cyc - start_cyc), 32'(LAT + 4));
        check("n2_dones", 32'(n_done - base_done), 32'd1);
        chk_rd("n2_fx0", 0, 0, 32'hFFFE_0000);
        chk_rd("n2_fx1", 1, 0, 32'h0002_0000);
        chk_rd("n2_fy0", 0, 1, 32'hFFFF_0000);
        check("n2_err", 32'(err), 32'd0);
        check("n2_busy", 32'(busy), 32'd0);
        check("n2_hold_xj", pipe_xj, 32'h0002_0000);

        // Stray result with no tag in flight
        @(negedge clk); inj_v = 1'b1; inj_f = 32'd5;
        @(negedge clk); inj_v = 1'b0;
        check("stray_err", 32'(err), 32'd1);
        chk_rd("stray_fx0", 0, 0, 32'hFFFE_0000);
        chk_rd("stray_fx1", 1, 0, 32'h0002_0000);

        // N=16 full sweep: x=k<<16, y=k, z=3k
        for (int k = 0; k < MAXA; k++) load(k, 32'(k) << 16, 32'(k), 32'(3 * k));
        kick(16);
        wait_done(400);
        check("n16_issues", 32'(n_issue - base_issue), 32'd120);
        check("n16_contig", 32'(log_cyc[base_issue + 119] - log_cyc[base_issue]), 32'd119);
        check("n16_p0_xi", log_xi[base_issue], 32'h0);
        check("n16_p0_xj", log_xj[base_issue], 32'h0001_0000);
        check("n16_p119_xi", log_xi[base_issue + 119], 32'h000E_0000);
        check("n16_p119_xj", log_xj[base_issue + 119], 32'h000F_0000);
        check("n16_err_clr", 32'(err), 32'd0);
        check("n16_dones", 32'(n_done - base_done), 32'd1);
        sum = '0;
        for (int k = 0; k < MAXA; k++) begin
            rd_addr = AW'(k);
            #1;
            sum = sum + rd_fx;
        end
        check("n16_fx_sum", sum, 32'd0);
        chk_rd("n16_fx0", 0, 0, 32'hFF88_0000);
        chk_rd("n16_fx15", 15, 0, 32'h0078_0000);
        chk_rd("n16_fy3", 3, 1, 32'hFFFF_FFB8);
        chk_rd("n16_fz10", 10, 2, 32'h0000_0078);

        // start / ld_we while busy are ignored
        kick(16);
        wait_issue(base_issue + 10, 100);
        @(negedge clk);
        start = 1'b1; ld_we = 1'b1; ld_addr = '0; ld_x = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0; ld_we = 1'b0;
        wait_done(400);
        repeat (30) @(negedge clk);
        check("busy_dones", 32'(n_done - base_done), 32'd1);
        check("busy_issues", 32'(n_issue - base_issue), 32'd120);
        check("busy_idle", 32'(busy), 32'd0);
        chk_rd("busy_fx0", 0, 0, 32'hFF88_0000);

        // N=1 and N=0 go straight to DONE
        for (int n = 1; n >= 0; n--) begin
            kick(n);
            wait_done(20);
            check("small_done_lat", 32'(done_cyc - start_cyc), 32'd2);
            check("small_issues", 32'(n_issue - base_issue), 32'd0);
            chk_rd("small_fx0", 0, 0, 32'd0);
            chk_rd("small_fx15", 15, 0, 32'd0);
            chk_rd("small_fy3", 3, 1, 32'd0);
        end

        // Reset during DRAIN aborts the run
        kick(16);
        wait_issue(base_issue + 120, 400);
        repeat (3) @(negedge clk);
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_vin", 32'(pipe_valid_in), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base_vout = n_vout;
        repeat (LAT + 6) @(negedge clk);
        check("abort_stray_seen", 32'(n_vout > base_vout), 32'd1);
        check("abort_err", 32'(err), 32'd0);
        check("abort_dones", 32'(n_done - base_done), 32'd0);
        chk_rd("abort_fx0", 0, 0, 32'd0);
        chk_rd("abort_fx15", 15, 0, 32'd0);
        chk_rd("abort_fy3", 3, 1, 32'd0);

        // Table was cleared by reset
        kick(16);
        wait_done(400);
        chk_rd("tblrst_fx15", 15, 0, 32'd0);
        chk_rd("tblrst_fz10", 10, 2, 32'd0);

`ifdef NB_CUTOFF_EN
        cutoff_box = 32'h0001_0000;
        load(0, 32'h0, 32'h0, 32'h0);
        load(1, 32'h0000_8000, 32'h0, 32'h0);
        load(2, 32'h0005_0000, 32'h0, 32'h0);
        kick(3);
        wait_done(100);
        check("cut_issues", 32'(n_issue - base_issue), 32'd1);
        check("cut_p0_xi", log_xi[base_issue], 32'h0);
        check("cut_p0_xj", log_xj[base_issue], 32'h0000_8000);
        chk_rd("cut_fx0", 0, 0, 32'hFFFF_8000);
        chk_rd("cut_fx1", 1, 0, 32'h0000_8000);
        chk_rd("cut_fx2", 2, 0, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
